// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the CPU memory-port arbiter.
// Contents:
//   arb_state_t : access sequencer states (IDLE, ISSUE, WAIT, RESP)
//   req_id_t    : requester identity (REQ_FETCH, REQ_DATA)
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
package cpu_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        REQ_FETCH,
        REQ_DATA
    } req_id_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times the memory read latency.
// Ports:
//   clk  in  : clock, rising edge
//   RST  in  : synchronous active-low reset (count -> 0)
//   load in  : load MEM_LAT (takes priority over dec)
//   dec  in  : decrement by one, saturating at 0
//   done out : count is 0
module mem_wait_counter #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic RST,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!RST) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(MEM_LAT);
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the instruction-fetch
// port and the data load/store port. Each access runs IDLE -> ISSUE ->
// WAIT -> RESP; the winner gets a one-cycle valid pulse and the core is
// stalled while any request is outstanding.
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants when both
// ports request together; otherwise data always beats fetch.
// Ports:
//   clk, RST                     : clock, synchronous active-low reset
//   i_req/i_addr/i_rdata/i_valid : fetch port
//   d_req/d_wr/d_addr/d_wdata/d_rdata/d_valid : data port
//   m_en/m_wr/m_addr/m_wdata/m_rdata : memory macro interface
//   stall                        : combinational stall to the core
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_valid,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              m_en,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              stall
);

    arb_state_t        state, state_nxt;
    req_id_t           winner;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_wr;
    logic              any_req;
    logic              grant_data;
    logic              start;
    logic              cnt_done;

    assign any_req = i_req | d_req;
    assign start   = (state == IDLE) && any_req;

`ifdef ARB_ROUND_ROBIN_EN
    req_id_t last_grant;

    // Data wins unless fetch is also asking and data had the last turn.
    assign grant_data = d_req & (~i_req | (last_grant == REQ_FETCH));

    always_ff @(posedge clk) begin
        if (!RST) begin
            last_grant <= REQ_FETCH;
        end else if (state == ISSUE) begin
            last_grant <= winner;
        end
    end
`else
    assign grant_data = d_req;
`endif

    // Counter is loaded on entry to ISSUE and counts through ISSUE and
    // WAIT, so it reaches 0 exactly in the cycle m_rdata is valid.
    mem_wait_counter #(
        .MEM_LAT(MEM_LAT)
    ) u_wait_cnt (
        .clk (clk),
        .RST (RST),
        .load(start),
        .dec ((state == ISSUE) || (state == WAIT)),
        .done(cnt_done)
    );

    always_ff @(posedge clk) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt_done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch: requesters hold their inputs, but latching keeps the
    // memory interface stable even if a requester misbehaves mid-access.
    always_ff @(posedge clk) begin
        if (!RST) begin
            winner    <= REQ_FETCH;
            lat_addr  <= '0;
            lat_wr    <= 1'b0;
            lat_wdata <= '0;
        end else if (start) begin
            winner    <= grant_data ? REQ_DATA : REQ_FETCH;
            lat_addr  <= grant_data ? d_addr : i_addr;
            lat_wr    <= grant_data & d_wr;
            lat_wdata <= d_wdata;
        end
    end

    // Read-data capture; stores leave d_rdata untouched.
    always_ff @(posedge clk) begin
        if (!RST) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else if ((state == WAIT) && cnt_done && !lat_wr) begin
            if (winner == REQ_DATA) begin
                d_rdata <= m_rdata;
            end else begin
                i_rdata <= m_rdata;
            end
        end
    end

    assign m_en    = (state == ISSUE);
    assign m_wr    = m_en & lat_wr;
    assign m_addr  = m_en ? lat_addr  : '0;
    assign m_wdata = m_en ? lat_wdata : '0;

    assign i_valid = (state == RESP) && (winner == REQ_FETCH);
    assign d_valid = (state == RESP) && (winner == REQ_DATA);

    assign stall = (i_req & ~i_valid) | (d_req & ~d_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk;
    logic        RST;
    // instance with MEM_LAT = 1
    logic        i_req, d_req, d_wr;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_valid, d_valid, m_en, m_wr, stall;
    // instance with MEM_LAT = 3
    logic        b_i_req, b_d_req, b_d_wr;
    logic [31:0] b_i_addr, b_d_addr, b_d_wdata, b_m_rdata;
    logic [31:0] b_i_rdata, b_d_rdata, b_m_addr, b_m_wdata;
    logic        b_i_valid, b_d_valid, b_m_en, b_m_wr, b_stall;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit          is_data;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut (
        .clk(clk), .RST(RST),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .m_en(m_en), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .stall(stall)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
        .clk(clk), .RST(RST),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_rdata(b_i_rdata), .i_valid(b_i_valid),
        .d_req(b_d_req), .d_wr(b_d_wr), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_rdata(b_d_rdata), .d_valid(b_d_valid),
        .m_en(b_m_en), .m_wr(b_m_wr), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
        .m_rdata(b_m_rdata), .stall(b_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Power-on memory contents of the model.
    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
    endfunction

    // Memory model, latency 1: read data only valid in the one cycle after m_en.
    logic [31:0] mem1 [256];
    bit          written [256];
    logic        rd1_vld = 1'b0;
    logic [31:0] rd1_q = '0;
    always @(posedge clk) begin
        rd1_vld <= m_en & ~m_wr;
        rd1_q   <= written[m_addr[9:2]] ? mem1[m_addr[9:2]] : pat(m_addr);
        if (m_en && m_wr) begin
            mem1[m_addr[9:2]]    <= m_wdata;
            written[m_addr[9:2]] <= 1'b1;
        end
    end
    assign m_rdata = rd1_vld ? rd1_q : 32'hBAD0BAD0;

    // Memory model, latency 3 (read-only).
    logic [2:0]  rd3_vld = '0;
    logic [31:0] rd3_q [3];
    always @(posedge clk) begin
        rd3_vld  <= {rd3_vld[1:0], b_m_en & ~b_m_wr};
        rd3_q[0] <= pat(b_m_addr);
        rd3_q[1] <= rd3_q[0];
        rd3_q[2] <= rd3_q[1];
    end
    assign b_m_rdata = rd3_vld[2] ? rd3_q[2] : 32'hBAD0BAD0;

    initial begin
        #400000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_data, input logic [31:0] data, input int due);
        exp_t e;
        e.is_data = is_data;
        e.data    = data;
        e.due     = due;
        sb.push_back(e);
    endtask

    // Poll for the next valid pulse on the latency-1 instance and score it.
    task automatic wait_resp(input string tag, input int max_cyc);
        bit   got;
        exp_t e;
        got = 1'b0;
        for (int k = 0; k < max_cyc && !got; k++) begin
            @(negedge clk);
            if (i_valid || d_valid) begin
                got = 1'b1;
                chk({tag, "_excl"}, {31'd0, i_valid & d_valid}, 32'd0);
                chk({tag, "_sb"}, sb.size(), (sb.size() == 0) ? 32'd1 : sb.size());
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk({tag, "_port"}, {31'd0, d_valid}, {31'd0, e.is_data});
                    chk({tag, "_data"}, d_valid ? d_rdata : i_rdata, e.data);
                    chk({tag, "_cycle"}, cyc, e.due);
                end
            end
        end
        chk({tag, "_got"}, {31'd0, got}, 32'd1);
    endtask

    int t0;
    bit rr;

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        RST = 1'b0;
        i_req = 0; i_addr = 0; d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
        b_i_req = 0; b_i_addr = 0; b_d_req = 0; b_d_wr = 0; b_d_addr = 0; b_d_wdata = 0;
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        chk("rst_i_valid", {31'd0, i_valid}, 32'd0);
        chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
        chk("rst_m_en", {31'd0, m_en}, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        tick();
        RST = 1'b1;
        tick();

        // 1: fetch only
        i_req = 1; i_addr = 32'h10; t0 = cyc;
        push(1'b0, 32'hDEADBEEF, t0 + 3);
        @(negedge clk);
        chk("t1_stall0", {31'd0, stall}, 32'd1);
        chk("t1_men0", {31'd0, m_en}, 32'd0);
        @(negedge clk);
        chk("t1_men1", {31'd0, m_en}, 32'd1);
        chk("t1_maddr", m_addr, 32'h10);
        chk("t1_mwr", {31'd0, m_wr}, 32'd0);
        wait_resp("t1", 5);
        tick();
        i_req = 0;
        @(negedge clk);
        chk("t1_stall_end", {31'd0, stall}, 32'd0);
        chk("t1_valid_end", {31'd0, i_valid}, 32'd0);

        // 2: both request, data first
        tick();
        d_req = 1; d_wr = 0; d_addr = 32'h200; i_req = 1; i_addr = 32'h10; t0 = cyc;
        push(1'b1, pat(32'h200), t0 + 3);
        push(1'b0, 32'hDEADBEEF, t0 + 7);
        @(negedge clk);
        @(negedge clk);
        chk("t2_maddr_d", m_addr, 32'h200);
        wait_resp("t2d", 4);
        tick();
        d_req = 0;
        @(negedge clk);
        chk("t2_men_idle", {31'd0, m_en}, 32'd0);
        chk("t2_stall_f", {31'd0, stall}, 32'd1);
        @(negedge clk);
        chk("t2_men_f", {31'd0, m_en}, 32'd1);
        chk("t2_maddr_f", m_addr, 32'h10);
        wait_resp("t2f", 4);
        tick();
        i_req = 0;

        // 3: store, then read it back
        tick();
        d_req = 1; d_wr = 1; d_addr = 32'h40; d_wdata = 32'h12345678; t0 = cyc;
        push(1'b1, pat(32'h200), t0 + 3);
        @(negedge clk);
        @(negedge clk);
        chk("t3_men", {31'd0, m_en}, 32'd1);
        chk("t3_mwr", {31'd0, m_wr}, 32'd1);
        chk("t3_maddr", m_addr, 32'h40);
        chk("t3_mwdata", m_wdata, 32'h12345678);
        wait_resp("t3st", 4);
        tick();
        d_wr = 0; t0 = cyc;
        push(1'b1, 32'h12345678, t0 + 3);
        wait_resp("t3ld", 6);
        tick();
        d_req = 0;

        // 4: reset during WAIT
        tick();
        i_req = 1; i_addr = 32'h44;
        @(negedge clk);
        @(negedge clk);
        chk("t4_men", {31'd0, m_en}, 32'd1);
        tick();
        RST = 0; i_req = 0;
        @(negedge clk);
        @(negedge clk);
        chk("t4_i_valid", {31'd0, i_valid}, 32'd0);
        chk("t4_m_en", {31'd0, m_en}, 32'd0);
        chk("t4_i_rdata", i_rdata, 32'd0);
        chk("t4_d_rdata", d_rdata, 32'd0);
        chk("t4_stall", {31'd0, stall}, 32'd0);
        tick();
        RST = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_no_pulse", {31'd0, i_valid | d_valid | m_en}, 32'd0);
        end
        tick();
        i_req = 1; i_addr = 32'h44; t0 = cyc;
        push(1'b0, pat(32'h44), t0 + 3);
        wait_resp("t4re", 6);
        tick();
        i_req = 0;

        // 5: both held continuously
        tick();
        d_req = 1; d_wr = 0; d_addr = 32'h200; i_req = 1; i_addr = 32'h10; t0 = cyc;
        for (int k = 0; k < 4; k++) begin
            if (rr && (k % 2 == 1)) push(1'b0, 32'hDEADBEEF, t0 + 3 + 4 * k);
            else                    push(1'b1, pat(32'h200), t0 + 3 + 4 * k);
        end
        for (int k = 0; k < 4; k++) begin
            wait_resp("t5", 6);
            chk("t5_stall", {31'd0, stall}, 32'd1);
        end
        tick();
        d_req = 0; i_req = 0;
        @(negedge clk);
        chk("t5_stall_end", {31'd0, stall}, 32'd0);
        chk("t5_sb_empty", sb.size(), 32'd0);

        // 6: latency-3 instance
        tick();
        b_i_req = 1; b_i_addr = 32'h80;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk("t6_stall", {31'd0, b_stall}, {31'd0, (c <= 4)});
            chk("t6_men", {31'd0, b_m_en}, {31'd0, (c == 1)});
            chk("t6_ivalid", {31'd0, b_i_valid}, {31'd0, (c == 5)});
            if (c == 1) chk("t6_maddr", b_m_addr, 32'h80);
            if (c == 5) begin
                chk("t6_rdata", b_i_rdata, pat(32'h80));
                tick();
                b_i_req = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
